// File: rtl/apb_mem_slave_if.sv
// APB completer bus bundle: requester-driven select/enable/address/data plus completer response.
// Latency: none, wiring only.
// Backpressure: the completer stalls the requester by holding pready low.
//
// Ports (signals):
//   psel, penable, pwrite, paddr, pwdata  - driven by the master
//   prdata, pready, pslverr               - driven by the slave
interface apb_mem_slave_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_mem_slave.sv
// APB completer backed by a word-addressed register memory, with error and optional wait-state responses.
// Latency: SETUP + ACCESS = 2 cycles; 2+WAIT_CYCLES when APB_SLV_WAIT_EN is defined.
// Backpressure: pready stays low during inserted wait cycles; dropping psel/penable in ACCESS aborts the transfer.
//
// Ports: pclk (clock, rising edge), presetn (async active-low reset),
//        apb (apb_mem_slave_if.slave: psel/penable/pwrite/paddr/pwdata in, prdata/pready/pslverr out).
// Optional build macro: APB_SLV_WAIT_EN enables WAIT_CYCLES pready-low cycles per ACCESS phase.
module apb_mem_slave #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic           pclk,
  input  logic           presetn,
  apb_mem_slave_if.slave apb
);

  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int AIW  = ADDR_WIDTH - 2;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  logic [1:0]            state;
  logic [1:0]            state_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [IDXW-1:0]       cap_idx;
  logic                  cap_write;
  logic [DATA_WIDTH-1:0] cap_wdata;
  logic                  cap_err;
  logic [DATA_WIDTH-1:0] rd_q;

  logic                  complete;
  logic                  capture;
  logic                  commit;
  logic [AIW-1:0]        in_idx;
  logic                  in_err;
  logic [DATA_WIDTH-1:0] rd_next;

  // Decode of the address presented in the setup phase.
  assign in_idx = apb.paddr[ADDR_WIDTH-1:2];
  assign in_err = (|apb.paddr[1:0]) || (32'(in_idx) >= DEPTH);

`ifdef APB_SLV_WAIT_EN
  localparam int              CNTW     = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNTW-1:0] WAIT_MAX = CNTW'(WAIT_CYCLES);

  logic [CNTW-1:0] wait_cnt;

  assign complete = (state == ACCESS) && (wait_cnt == WAIT_MAX);

  // Counts only while the access phase is held; any exit or abort clears it.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      wait_cnt <= '0;
    end else if ((state == ACCESS) && !complete && apb.psel && apb.penable) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end
`else
  logic [31:0] unused_wait_cycles;
  assign unused_wait_cycles = 32'(WAIT_CYCLES);
  assign complete = (state == ACCESS);
`endif

  // A new setup phase is accepted from IDLE or directly on a completion edge.
  assign capture = apb.psel && !apb.penable && ((state == IDLE) || complete);
  assign commit  = complete && cap_write && !cap_err;

  // A write committing on this edge is not yet visible in mem, so a
  // back-to-back read of the same word takes the captured write data.
  always_comb begin
    rd_next = '0;
    if (!in_err) begin
      if (commit && (cap_idx == in_idx[IDXW-1:0])) begin
        rd_next = cap_wdata;
      end else begin
        rd_next = mem[in_idx[IDXW-1:0]];
      end
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        // psel with penable but no setup phase is ignored.
        if (apb.psel && !apb.penable) state_d = SETUP;
      end
      SETUP: begin
        if (!apb.psel)        state_d = IDLE;
        else if (apb.penable) state_d = ACCESS;
      end
      ACCESS: begin
        if (complete)                         state_d = (apb.psel && !apb.penable) ? SETUP : IDLE;
        else if (!apb.psel || !apb.penable)   state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state     <= IDLE;
      cap_idx   <= '0;
      cap_write <= 1'b0;
      cap_wdata <= '0;
      cap_err   <= 1'b0;
      rd_q      <= '0;
    end else begin
      state <= state_d;
      if (capture) begin
        cap_idx   <= in_idx[IDXW-1:0];
        cap_write <= apb.pwrite;
        cap_wdata <= apb.pwdata;
        cap_err   <= in_err;
        rd_q      <= apb.pwrite ? '0 : rd_next;
      end
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (commit) begin
      mem[cap_idx] <= cap_wdata;
    end
  end

  assign apb.pready  = complete;
  assign apb.pslverr = complete && cap_err;
  assign apb.prdata  = (complete && !cap_write) ? rd_q : '0;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Directed bench for apb_mem_slave: driver issues APB transfers, monitor scores responses from a queue.
// Latency: expects pready in the first ACCESS cycle, or after WAIT_CYCLES waits with APB_SLV_WAIT_EN.
// Backpressure: the driver holds the access phase until pready, bounded by a cycle budget.
module tb_apb_mem_slave;

  localparam int AW = 8;
  localparam int DW = 32;
`ifdef APB_SLV_WAIT_EN
  localparam int EXP_WAITS = 2;
`else
  localparam int EXP_WAITS = 0;
`endif

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
  } resp_t;

  logic  pclk = 1'b0;
  logic  presetn;
  int    checks = 0;
  int    passes = 0;
  resp_t exp_q[$];
  resp_t mon_e;

  apb_mem_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_mem_slave #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (32),
    .WAIT_CYCLES(2)
  ) dut (
    .pclk   (pclk),
    .presetn(presetn),
    .apb    (bus.slave)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  // Monitor: scores every completion against the scoreboard; outside completion
  // cycles prdata and pslverr must be quiet.
  always @(negedge pclk) begin
    if (presetn === 1'b1) begin
      if (bus.pready === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pready", {31'b0, bus.pready}, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("prdata", bus.prdata, mon_e.rdata);
          check("pslverr", {31'b0, bus.pslverr}, {31'b0, mon_e.err});
        end
      end else begin
        check("quiet_outputs", bus.prdata | {31'b0, bus.pslverr}, 32'd0);
      end
    end
  end

  // Full transfer starting at posedge+1; returns in the completion cycle so the
  // caller can either go idle or start the next setup back-to-back.
  task automatic xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                      input logic [DW-1:0] exp_rd, input logic exp_err);
    resp_t r;
    int    waits;
    r.rdata = wr ? '0 : exp_rd;
    r.err   = exp_err;
    exp_q.push_back(r);
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = wr;
    bus.paddr   = addr;
    bus.pwdata  = wdata;
    @(posedge pclk); #1;
    bus.penable = 1'b1;
    // Scramble address/data during ACCESS; the captured values must be used.
    bus.paddr   = ~addr;
    bus.pwdata  = ~wdata;
    waits = 0;
    @(posedge pclk); #1;
    while (bus.pready !== 1'b1 && waits < 20) begin
      waits++;
      @(posedge pclk); #1;
    end
    check("pready_seen", {31'b0, bus.pready}, 32'd1);
    check("wait_states", waits, EXP_WAITS);
  endtask

  task automatic go_idle();
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    @(posedge pclk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d passes=%0d", checks, passes);
    $fatal(1, "watchdog");
  end

  initial begin
    presetn     = 1'b0;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    bus.paddr   = '0;
    bus.pwdata  = '0;
    repeat (2) @(posedge pclk);
    #1;
    check("rst_pready", {31'b0, bus.pready}, 32'd0);
    check("rst_pslverr", {31'b0, bus.pslverr}, 32'd0);
    check("rst_prdata", bus.prdata, 32'd0);
    presetn = 1'b1;
    @(posedge pclk); #1;

    // Basic write then read, plus a second word.
    xfer(1'b1, 8'h10, 32'hDEADBEEF, 32'h0, 1'b0); go_idle();
    xfer(1'b0, 8'h10, 32'h0, 32'hDEADBEEF, 1'b0); go_idle();
    xfer(1'b1, 8'h04, 32'h12345678, 32'h0, 1'b0); go_idle();
    xfer(1'b0, 8'h04, 32'h0, 32'h12345678, 1'b0); go_idle();

    // Out-of-range and misaligned accesses; 0x06 shares word 1 with 0x04.
    xfer(1'b1, 8'h80, 32'hAAAA5555, 32'h0, 1'b1); go_idle();
    xfer(1'b1, 8'h06, 32'h5A5A5A5A, 32'h0, 1'b1); go_idle();
    xfer(1'b0, 8'h80, 32'h0, 32'h0, 1'b1); go_idle();
    xfer(1'b0, 8'h06, 32'h0, 32'h0, 1'b1); go_idle();
    xfer(1'b0, 8'h04, 32'h0, 32'h12345678, 1'b0); go_idle();

    // Last valid word.
    xfer(1'b1, 8'h7C, 32'hCAFEF00D, 32'h0, 1'b0); go_idle();
    xfer(1'b0, 8'h7C, 32'h0, 32'hCAFEF00D, 1'b0); go_idle();

    // Back-to-back: same-word bypass, then a different word.
    xfer(1'b1, 8'h08, 32'h00000011, 32'h0, 1'b0);
    xfer(1'b0, 8'h08, 32'h0, 32'h00000011, 1'b0);
    xfer(1'b1, 8'h0C, 32'h00000022, 32'h0, 1'b0);
    xfer(1'b0, 8'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    xfer(1'b0, 8'h0C, 32'h0, 32'h00000022, 1'b0); go_idle();

    // Transfer aborted after its setup phase.
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = 8'h10; bus.pwdata = 32'h99;
    @(posedge pclk); #1;
    go_idle();
    xfer(1'b0, 8'h10, 32'h0, 32'hDEADBEEF, 1'b0); go_idle();

`ifdef APB_SLV_WAIT_EN
    // Transfer aborted in a wait cycle of its access phase.
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = 8'h04; bus.pwdata = 32'h00000BAD;
    @(posedge pclk); #1;
    bus.penable = 1'b1;
    @(posedge pclk); #1;
    check("abort_wait_pready", {31'b0, bus.pready}, 32'd0);
    go_idle();
    check("abort_idle_pready", {31'b0, bus.pready}, 32'd0);
    xfer(1'b0, 8'h04, 32'h0, 32'h12345678, 1'b0); go_idle();
`endif

    // Access phase with no setup phase gets no response.
    bus.psel = 1'b1; bus.penable = 1'b1; bus.pwrite = 1'b1;
    bus.paddr = 8'h10; bus.pwdata = 32'h55;
    for (int i = 0; i < 3; i++) begin
      @(posedge pclk); #1;
      check("nosetup_pready", {31'b0, bus.pready}, 32'd0);
    end
    go_idle();
    xfer(1'b0, 8'h10, 32'h0, 32'hDEADBEEF, 1'b0); go_idle();

    // Reset in the first access cycle of a write.
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = 8'h0C; bus.pwdata = 32'h77;
    @(posedge pclk); #1;
    bus.penable = 1'b1;
    @(posedge pclk); #1;
    presetn = 1'b0;
    #1;
    check("midrst_pready", {31'b0, bus.pready}, 32'd0);
    check("midrst_pslverr", {31'b0, bus.pslverr}, 32'd0);
    check("midrst_prdata", bus.prdata, 32'd0);
    bus.psel = 1'b0; bus.penable = 1'b0;
    @(posedge pclk); #1;
    presetn = 1'b1;
    @(posedge pclk); #1;

    // Everything written earlier must be cleared.
    xfer(1'b0, 8'h10, 32'h0, 32'h0, 1'b0);
    xfer(1'b0, 8'h04, 32'h0, 32'h0, 1'b0);
    xfer(1'b0, 8'h08, 32'h0, 32'h0, 1'b0);
    xfer(1'b0, 8'h0C, 32'h0, 32'h0, 1'b0);
    xfer(1'b0, 8'h7C, 32'h0, 32'h0, 1'b0); go_idle();

    repeat (3) @(posedge pclk);
    #1;
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
